alu_eval_pipe: RTL and testbench
================================

Name: alu_eval_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational 8-bit evaluation arithmetic: add, add-with-carry-in, concatenation, reduction AND/OR, and a running accumulator.
- Operands arrive with a valid/ready handshake. Results leave through a 2-stage registered pipeline with backpressure.
- Sits between operand sources (testbench or register file) and any consumer that needs width-exact results plus status flags.

Parameters:
- W, 8, operand width in bits (W >= 2).
- RW, 2*W, result width; fixed as 2*W and not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block accepts the beat this cycle.
- op  in  3  operation code (see Behaviour).
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in; used only by ADDC.
- out_valid  out  1  result beat available.
- out_ready  in  1  consumer takes the result.
- result  out  RW  zero-extended result.
- carry  out  1  carry-out of ADD/ADDC/ACC.
- zero  out  1  result == 0.
- err  out  1  reserved opcode was issued.

Behaviour:
- Reset: all pipeline valids, result, carry, zero, err and the internal accumulator acc[RW-1:0] clear to 0 immediately and asynchronously. After reset, in_ready=1.
- Opcodes:
  - 0 ADD: result = a + b (W+1 bits, zero-extended). carry = bit W.
  - 1 ADDC: result = a + b + cin. carry = bit W. 255+155+1 = 411 for W=8.
  - 2 CAT: result = {a, b}. carry = 0.
  - 3 RAND: result = &b in bit 0, rest 0.
  - 4 ROR: result = |b in bit 0, rest 0.
  - 5 ACC: acc <= acc + zero-extended a, wrapping mod 2^RW. result = new acc value. carry = wrap-out bit.
  - 6 ACLR: acc <= 0. result = 0.
  - 7 reserved: result = 0, err = 1, acc unchanged.
- err is per-beat: it accompanies only the beat that carried op 7.
- zero is computed on the final result for every op.
- Handshake:
  - A beat transfers on in_valid && in_ready.
  - A result transfers on out_valid && out_ready.
  - in_valid may drop without a transfer; the block must not depend on it staying high.
- Pipeline:
  - Stage 1 registers the operation result, including the acc update. Stage 2 registers the flags and drives the outputs.
  - Latency is 2 cycles from accept to out_valid with no stall. Throughput is 1 beat/cycle while out_ready=1.
- Stall rules:
  - A stage advances when its successor is empty or is being drained in the same cycle.
  - in_ready = !s1_valid || s1_advance, and is combinational from out_ready.
  - Outputs hold stable while out_valid && !out_ready.
- Accumulator:
  - acc updates exactly once per accepted ACC/ACLR beat, at accept time, never during a stall.
  - Back-to-back ACC beats chain correctly with no hazard, because the stage-1 compute uses the live acc register.
- Reset mid-operation: in-flight beats are discarded, with no partial output. acc returns to 0.
- Width: all arithmetic is unsigned. No truncation except the ACC wrap at RW bits.

Decomposition:
- Package alu_eval_pkg holds:
  - the op enum: OP_ADD=0, OP_ADDC=1, OP_CAT=2, OP_RAND=3, OP_ROR=4, OP_ACC=5, OP_ACLR=6, OP_RSVD=7;
  - the result/flag struct.
- One sub-module, alu_eval_core, is natural. It is purely combinational: inputs op, a, b, cin, acc; outputs next result, carry and err.
- The top level holds the handshake, the two pipeline registers and acc.

Test Plan:
- W=8, ADD a=255 b=155, out_ready=1: 2 cycles later result=0x019A, carry=1, zero=0, err=0.
- ADDC with same operands, cin=1: result=0x019B, carry=1. CAT with same operands: result=0xFF9B.
- RAND b=155: result=0, zero=1. Then RAND b=255: result=1. Then ROR b=0: result=0, zero=1.
- ACLR, then ACC a=255 three times back-to-back: results 255, 510, 765. Then with W=4, ACC a=15 to overflow: acc wraps at 256 and carry=1 on the wrap beat.
- Hold out_ready=0 for 5 cycles with 3 beats offered:
  - in_ready drops after the pipeline fills (2 beats held);
  - result stays stable throughout;
  - on release, beats exit in order with none lost or duplicated.
- Assert rst_n low mid-stream with acc=765 and both stages full: out_valid=0 and acc=0 immediately. Op 7 after reset: err=1, result=0.

Source files
------------

// File: rtl/alu_eval_pkg.sv
// Shared opcode and flag definitions for the pipelined evaluation ALU.
package alu_eval_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADDC = 3'd1,
        OP_CAT  = 3'd2,
        OP_RAND = 3'd3,
        OP_ROR  = 3'd4,
        OP_ACC  = 3'd5,
        OP_ACLR = 3'd6,
        OP_RSVD = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_eval_pipe_if.sv
// Operand/result handshake bundle for alu_eval_pipe; slave is the ALU side.
interface alu_eval_pipe_if #(
    parameter int W = 8
);
    localparam int RW = 2 * W;

    logic          in_valid;
    logic          in_ready;
    logic [2:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          carry;
    logic          zero;
    logic          err;

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, carry, zero, err
    );

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, carry, zero, err
    );

endinterface

// File: rtl/alu_eval_core.sv
// Combinational operation datapath; acc is the live accumulator so ACC beats chain.
module alu_eval_core
    import alu_eval_pkg::*;
#(
    parameter int W = 8
) (
    input  alu_op_e          op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             cin,
    input  logic [2*W-1:0]   acc,
    output logic [2*W-1:0]   res,
    output logic             carry,
    output logic             err
);
    localparam int RW = 2 * W;

    logic [W:0]  sum;
    logic [RW:0] acc_sum;

    assign sum     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, (op == OP_ADDC) && cin};
    assign acc_sum = {1'b0, acc} + {{(W+1){1'b0}}, a};

    always_comb begin
        res   = '0;
        carry = 1'b0;
        err   = 1'b0;
        unique case (op)
            OP_ADD, OP_ADDC: begin
                res   = {{(W-1){1'b0}}, sum};
                carry = sum[W];
            end
            OP_CAT:  res = {a, b};
            OP_RAND: res[0] = &b;
            OP_ROR:  res[0] = |b;
            OP_ACC: begin
                res   = acc_sum[RW-1:0];
                carry = acc_sum[RW];
            end
            OP_ACLR: res = '0;
            OP_RSVD: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_eval_pipe.sv
// Two-stage pipelined evaluation ALU with valid/ready backpressure and a running accumulator.
module alu_eval_pipe
    import alu_eval_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_eval_pipe_if.slave  bus
);
    localparam int RW = 2 * W;

    alu_op_e       op_in;
    logic [RW-1:0] acc;
    logic [RW-1:0] core_res;
    logic          core_carry;
    logic          core_err;

    logic          s1_valid;
    logic [RW-1:0] s1_result;
    logic          s1_carry;
    logic          s1_err;

    logic          s2_valid;
    logic [RW-1:0] s2_result;
    alu_flags_t    s2_flags;

    logic          s1_advance;
    logic          accept;

    assign op_in      = alu_op_e'(bus.op);
    assign s1_advance = s1_valid && (!s2_valid || bus.out_ready);
    assign bus.in_ready = !s1_valid || s1_advance;
    assign accept     = bus.in_valid && bus.in_ready;

    alu_eval_core #(.W(W)) u_core (
        .op    (op_in),
        .a     (bus.a),
        .b     (bus.b),
        .cin   (bus.cin),
        .acc   (acc),
        .res   (core_res),
        .carry (core_carry),
        .err   (core_err)
    );

    // acc only moves on an accepted beat, so stalls can never double-apply an ACC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && (op_in == OP_ACC || op_in == OP_ACLR)) begin
            acc <= core_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_result <= '0;
            s1_carry  <= 1'b0;
            s1_err    <= 1'b0;
        end else if (accept) begin
            s1_valid  <= 1'b1;
            s1_result <= core_res;
            s1_carry  <= core_carry;
            s1_err    <= core_err;
        end else if (s1_advance) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
        end else if (s1_advance) begin
            s2_valid       <= 1'b1;
            s2_result      <= s1_result;
            s2_flags.carry <= s1_carry;
            s2_flags.zero  <= (s1_result == '0);
            s2_flags.err   <= s1_err;
        end else if (bus.out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_result;
    assign bus.carry     = s2_flags.carry;
    assign bus.zero      = s2_flags.zero;
    assign bus.err       = s2_flags.err;

endmodule

// File: tb/tb_alu_eval_pipe.sv
// Scoreboard bench for alu_eval_pipe at W=8 and W=4 with directed, hand-computed vectors.
module tb_alu_eval_pipe;
    import alu_eval_pkg::*;

    typedef struct {
        logic [15:0] result;
        logic        carry;
        logic        zero;
        logic        err;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_eval_pipe_if #(.W(8)) b8 ();
    alu_eval_pipe_if #(.W(4)) b4 ();

    alu_eval_pipe #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    alu_eval_pipe #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    exp_t sb8[$];
    exp_t sb4[$];
    exp_t e8, e4;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic c, input logic z,
                                input logic er, input string n);
        exp_t x;
        x.result = r; x.carry = c; x.zero = z; x.err = er; x.name = n;
        return x;
    endfunction

    // monitors: compare whenever a result transfers, in order
    always @(negedge clk) begin
        #2;
        if (rst_n && b8.out_valid && b8.out_ready) begin
            if (sb8.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL w8 unexpected beat: got result 0x%0h, required no beat", b8.result);
            end else begin
                e8 = sb8.pop_front();
                chk(e8.name, {13'b0, b8.err, b8.zero, b8.carry, b8.result},
                    {13'b0, e8.err, e8.zero, e8.carry, e8.result});
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (rst_n && b4.out_valid && b4.out_ready) begin
            if (sb4.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL w4 unexpected beat: got result 0x%0h, required no beat", b4.result);
            end else begin
                e4 = sb4.pop_front();
                chk(e4.name, {13'b0, b4.err, b4.zero, b4.carry, 8'h00, b4.result},
                    {13'b0, e4.err, e4.zero, e4.carry, e4.result});
            end
        end
    end

    task automatic drive8(input alu_op_e op, input logic [7:0] a, input logic [7:0] b, input logic cin);
        b8.in_valid = 1'b1; b8.op = op; b8.a = a; b8.b = b; b8.cin = cin;
    endtask

    task automatic accept8(input exp_t x);
        int t = 0;
        #1;
        while (!b8.in_ready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (!b8.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s accept timeout: got in_ready=0, required 1", x.name);
            b8.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb8.push_back(x);
        end
    endtask

    task automatic send8(input alu_op_e op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input exp_t x);
        @(negedge clk);
        drive8(op, a, b, cin);
        accept8(x);
    endtask

    task automatic send4(input alu_op_e op, input logic [3:0] a, input logic [3:0] b, input exp_t x);
        int t = 0;
        @(negedge clk);
        b4.in_valid = 1'b1; b4.op = op; b4.a = a; b4.b = b; b4.cin = 1'b0;
        #1;
        while (!b4.in_ready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (!b4.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s accept timeout: got in_ready=0, required 1", x.name);
            b4.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb4.push_back(x);
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        @(negedge clk);
        b8.in_valid = 1'b0;
        b4.in_valid = 1'b0;
        while ((sb8.size() != 0 || sb4.size() != 0) && t < 100) begin
            @(negedge clk); t++;
        end
        #3;
        chk(name, 32'(sb8.size() + sb4.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        b8.in_valid = 1'b0; b8.op = '0; b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.op = '0; b4.a = '0; b4.b = '0; b4.cin = 1'b0; b4.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", 32'(b8.out_valid), 32'd0);
        chk("reset in_ready",  32'(b8.in_ready),  32'd1);
        chk("reset result",    32'(b8.result),    32'd0);
        chk("reset acc",       32'(dut8.acc),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // latency: accept edge, then out_valid one edge later
        send8(OP_ADD, 8'd255, 8'd155, 1'b0, mk(16'h019A, 1'b1, 1'b0, 1'b0, "add 255+155"));
        @(negedge clk); b8.in_valid = 1'b0; #1;
        chk("latency cycle1 out_valid", 32'(b8.out_valid), 32'd0);
        @(negedge clk); #1;
        chk("latency cycle2 out_valid", 32'(b8.out_valid), 32'd1);

        send8(OP_ADDC, 8'd255, 8'd155, 1'b1, mk(16'h019B, 1'b1, 1'b0, 1'b0, "addc 255+155+1"));
        send8(OP_CAT,  8'd255, 8'd155, 1'b0, mk(16'hFF9B, 1'b0, 1'b0, 1'b0, "cat ff,9b"));
        send8(OP_RAND, 8'd0,   8'd155, 1'b0, mk(16'h0000, 1'b0, 1'b1, 1'b0, "rand 155"));
        send8(OP_RAND, 8'd0,   8'd255, 1'b0, mk(16'h0001, 1'b0, 1'b0, 1'b0, "rand 255"));
        send8(OP_ROR,  8'd0,   8'd0,   1'b0, mk(16'h0000, 1'b0, 1'b1, 1'b0, "ror 0"));
        send8(OP_ACLR, 8'd9,   8'd9,   1'b0, mk(16'h0000, 1'b0, 1'b1, 1'b0, "aclr"));
        send8(OP_ACC,  8'd255, 8'd0,   1'b0, mk(16'd255,  1'b0, 1'b0, 1'b0, "acc 255"));
        send8(OP_ACC,  8'd255, 8'd0,   1'b0, mk(16'd510,  1'b0, 1'b0, 1'b0, "acc 510"));
        send8(OP_ACC,  8'd255, 8'd0,   1'b0, mk(16'd765,  1'b0, 1'b0, 1'b0, "acc 765"));
        drain("w8 directed drain");

        // stall: two beats fill the pipe, third waits
        @(negedge clk);
        b8.out_ready = 1'b0;
        drive8(OP_ADD, 8'd1, 8'd2, 1'b0);
        accept8(mk(16'd3, 1'b0, 1'b0, 1'b0, "stall beat1"));
        send8(OP_ADD, 8'd16, 8'd32, 1'b0, mk(16'd48, 1'b0, 1'b0, 1'b0, "stall beat2"));
        @(negedge clk);
        drive8(OP_CAT, 8'h12, 8'h34, 1'b0);
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk) ;
            #1;
            chk("stall in_ready",  32'(b8.in_ready),  32'd0);
            chk("stall out_valid", 32'(b8.out_valid), 32'd1);
            chk("stall result",    32'(b8.result),    32'd3);
        end
        b8.out_ready = 1'b1;
        accept8(mk(16'h1234, 1'b0, 1'b0, 1'b0, "stall beat3"));
        drain("stall drain");

        // reset with both stages full and acc=765
        @(negedge clk);
        b8.out_ready = 1'b0;
        drive8(OP_ADD, 8'd1, 8'd1, 1'b0);
        accept8(mk(16'd2, 1'b0, 1'b0, 1'b0, "pre-reset beat1"));
        send8(OP_ADD, 8'd2, 8'd2, 1'b0, mk(16'd4, 1'b0, 1'b0, 1'b0, "pre-reset beat2"));
        @(negedge clk);
        b8.in_valid = 1'b0;
        #1;
        chk("pre-reset acc",       32'(dut8.acc),     32'd765);
        chk("pre-reset out_valid", 32'(b8.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid reset out_valid", 32'(b8.out_valid), 32'd0);
        chk("mid reset acc",       32'(dut8.acc),     32'd0);
        chk("mid reset in_ready",  32'(b8.in_ready),  32'd1);
        sb8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        b8.out_ready = 1'b1;

        send8(OP_RSVD, 8'd3, 8'd4, 1'b0, mk(16'h0000, 1'b0, 1'b1, 1'b1, "reserved op"));
        send8(OP_ACC,  8'd5, 8'd0, 1'b0, mk(16'd5,    1'b0, 1'b0, 1'b0, "acc after reset"));
        send8(OP_ADD,  8'd0, 8'd0, 1'b0, mk(16'h0000, 1'b0, 1'b1, 1'b0, "add 0+0"));
        drain("post-reset drain");

        // W=4: RW=8, acc wraps at 256
        send4(OP_ACLR, 4'd0,  4'd0,  mk(16'h0000, 1'b0, 1'b1, 1'b0, "w4 aclr"));
        send4(OP_ADD,  4'd15, 4'd15, mk(16'h001E, 1'b1, 1'b0, 1'b0, "w4 add 15+15"));
        send4(OP_CAT,  4'hA,  4'h5,  mk(16'h00A5, 1'b0, 1'b0, 1'b0, "w4 cat a,5"));
        for (int unsigned k = 1; k <= 17; k++) begin
            send4(OP_ACC, 4'd15, 4'd0, mk(16'(15 * k), 1'b0, 1'b0, 1'b0, "w4 acc chain"));
        end
        send4(OP_ACC, 4'd15, 4'd0, mk(16'd14, 1'b1, 1'b0, 1'b0, "w4 acc wrap"));
        drain("w4 drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
